// File: rtl/xil_mem_arb_pkg.sv
// Shared constants and state encoding for the block-memory port arbiters.
package xil_mem_arb_pkg;

  localparam int unsigned MEM_AW = 9;
  localparam int unsigned MEM_DW = 16;
  localparam int unsigned MEM_BW = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/xil_mem_rr_pick.sv
// Combinational rotating-priority picker: the first requester at or after ptr
// (modulo NREQ) gets a one-hot grant.
module xil_mem_rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  int unsigned idx;
  logic        found;

  // Scan from ptr upwards with wrap-around; first active request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xil_mem_dp_arb.sv
// Round-robin arbiter sharing one port of the 512x16 dual-port block memory
// among NREQ requesters, with bounded burst locking and 1-cycle read return.
// Optional feature macro: XIL_MEM_ARB_STATS_EN adds per-requester wait counters.
module xil_mem_dp_arb
  import xil_mem_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_lock,
  input  logic [MEM_BW*NREQ-1:0]   i_wen,
  input  logic [MEM_AW*NREQ-1:0]   i_adr,
  input  logic [MEM_DW*NREQ-1:0]   i_wdata,
  output logic [NREQ-1:0]          o_gnt,
  output logic [NREQ-1:0]          o_rvalid,
  output logic [MEM_DW-1:0]        o_rdata,
  output logic                     o_mem_en,
  output logic [MEM_BW-1:0]        o_mem_wen,
  output logic [MEM_AW-1:0]        o_mem_adr,
  output logic [MEM_DW-1:0]        o_mem_wdata,
`ifdef XIL_MEM_ARB_STATS_EN
  output logic [16*NREQ-1:0]       o_wait_cnt,
`endif
  input  logic [MEM_DW-1:0]        i_mem_rdata
);

  localparam int unsigned PW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [7:0]      burst_q, burst_d;
  logic [NREQ-1:0] rvalid_q;

  logic            released;
  logic            exclusive;
  logic [PW-1:0]   owner_next;
  logic [PW-1:0]   pick_ptr;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] gnt;

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
    return (v == PW'(NREQ - 1)) ? '0 : v + PW'(1);
  endfunction

  // A lock ends when the owner stops requesting or its burst budget is spent;
  // that cycle arbitrates normally with the owner at lowest priority.
  always_comb begin
    owner_next = inc_wrap(owner_q);
    released   = (state_q == ARB_LOCKED) &&
                 (!i_req[owner_q] || (burst_q >= 8'(MAX_BURST)));
    exclusive  = (state_q == ARB_LOCKED) && !released;
    pick_ptr   = released ? owner_next : ptr_q;
  end

  xil_mem_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req (i_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt)
  );

  // Grant selection and next-state for pointer and lock FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    burst_d = burst_q;
    gnt     = '0;
    if (exclusive) begin
      gnt[owner_q] = 1'b1;
      burst_d      = burst_q + 8'd1;
      if (!i_lock[owner_q]) begin
        state_d = ARB_IDLE;
        ptr_d   = owner_next;
      end
    end else begin
      gnt     = pick_gnt;
      state_d = ARB_IDLE;
      ptr_d   = pick_ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (pick_gnt[k]) begin
          if (i_lock[k]) begin
            state_d = ARB_LOCKED;
            owner_d = PW'(k);
            burst_d = 8'd1;
          end else begin
            ptr_d = inc_wrap(PW'(k));
          end
        end
      end
    end
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    o_gnt       = rst_n ? gnt : '0;
    o_mem_en    = |o_gnt;
    o_mem_wen   = '0;
    o_mem_adr   = '0;
    o_mem_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (o_gnt[k]) begin
        o_mem_wen   = i_wen[MEM_BW*k +: MEM_BW];
        o_mem_adr   = i_adr[MEM_AW*k +: MEM_AW];
        o_mem_wdata = i_wdata[MEM_DW*k +: MEM_DW];
      end
    end
    o_rvalid = rvalid_q;
    o_rdata  = i_mem_rdata;
  end

  // Arbiter state and read-return strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      burst_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      for (int unsigned k = 0; k < NREQ; k++) begin
        rvalid_q[k] <= o_gnt[k] & (i_wen[MEM_BW*k +: MEM_BW] == '0);
      end
    end
  end

`ifdef XIL_MEM_ARB_STATS_EN
  logic [NREQ-1:0][15:0] wait_q;

  // Saturating per-requester count of cycles spent requesting without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (i_req[k] && !o_gnt[k] && (wait_q[k] != 16'hFFFF)) begin
          wait_q[k] <= wait_q[k] + 16'd1;
        end
      end
    end
  end

  assign o_wait_cnt = wait_q;
`endif

endmodule

// File: doc/xil_mem_dp_arb.md
Name: xil_mem_dp_arb

Overview:
Round-robin arbiter that shares one port of the 512x16 dual-port block memory among NREQ requesters on a single clock domain.
- Issues at most one access per cycle; byte-write enables pass through unchanged.
- Returns read data with a one-cycle valid strobe to the requester that issued the read.
- Supports a bounded "lock" for back-to-back bursts by one requester.
- Sits between engine-side clients (DMA, mailbox, counters) and memory port 0 or port 1.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 8, maximum consecutive locked grants to one requester before the lock is forced open (1..255).

Ports:
- clk  in  1  clock; also the memory port clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  NREQ  per-requester access request, level; held until granted.
- i_lock  in  NREQ  per-requester burst lock, sampled only with the granted request.
- i_wen  in  2*NREQ  byte write enables, requester k at [2k+1:2k]; 2'b00 means read.
- i_adr  in  9*NREQ  word address, requester k at [9k+8:9k].
- i_wdata  in  16*NREQ  write data, requester k at [16k+15:16k].
- o_gnt  out  NREQ  one-hot grant; the access is performed in this cycle.
- o_rvalid  out  NREQ  one-hot; read data is valid on o_rdata.
- o_rdata  out  16  read data, shared by all requesters.
- o_mem_en  out  1  memory port enable.
- o_mem_wen  out  2  memory byte write enables.
- o_mem_adr  out  9  memory address.
- o_mem_wdata  out  16  memory write data.
- i_mem_rdata  in  16  memory read data; valid the cycle after the enable.

Behaviour:
- Grant logic
  - o_gnt is combinational from i_req, the rotating pointer and the lock state.
  - A requester sees its grant in the same cycle it is performed and drops or changes i_req after the rising edge.
- Round-robin
  - Pointer ptr_q (log2 NREQ bits) names the highest-priority requester; priority descends ptr_q, ptr_q+1, … modulo NREQ.
  - After an unlocked grant to k, ptr_q becomes (k+1) mod NREQ.
  - With no grant, ptr_q holds.
- Memory signals
  - o_mem_en = |o_gnt.
  - o_mem_wen, o_mem_adr and o_mem_wdata are muxed from the granted requester.
  - With no grant, all three are driven to 0.
- Read return
  - Registered rvalid_q[k] <= o_gnt[k] & (i_wen slice k == 0).
  - o_rvalid = rvalid_q, and o_rdata = i_mem_rdata.
  - Fixed read latency is 1 cycle; writes return nothing.
- Lock FSM, states IDLE and LOCKED
  - IDLE -> LOCKED when the granted requester k has i_lock[k]=1: store owner_q=k and set burst_q=1.
  - In LOCKED:
    - If i_req[owner_q]=1 and burst_q<MAX_BURST, owner_q is granted exclusively and burst_q increments.
    - If i_req[owner_q]=0 or i_lock[owner_q]=0 on its grant, go to IDLE and set ptr_q=owner_q+1. The owner's final grant, if any, still occurs.
    - If burst_q==MAX_BURST, go to IDLE for one cycle and grant normally with ptr_q=owner_q+1, so the owner has lowest priority. The owner may re-lock when it next wins.
  - burst_q is 8 bits.
- Write collisions
  - Simultaneous read/write to the same address from the other memory port is outside this block.
  - The memory resolves such collisions as write-first.
- Reset
  - Asynchronous, active low: ptr_q=0, state IDLE, owner_q=0, burst_q=0, rvalid_q=0.
  - All outputs are 0 during reset and in the first cycle after release unless requests are present.
  - A read granted on the edge at which reset asserts produces no rvalid.

Optional Feature:
- Macro XIL_MEM_ARB_STATS_EN.
- When defined:
  - Adds output o_wait_cnt (16*NREQ).
  - Per-requester 16-bit saturating counters increment each cycle i_req[k]=1 and o_gnt[k]=0.
  - Counters are cleared by reset; they stick at 16'hFFFF.
- When undefined: the port and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package xil_mem_arb_pkg holds:
  - constants MEM_AW=9, MEM_DW=16, MEM_BW=2;
  - state encoding ARB_IDLE=1'b0, ARB_LOCKED=1'b1.
- Sub-module xil_mem_rr_pick is natural: a combinational rotating-priority one-hot picker with inputs req and ptr, output gnt.
  - It is reused by other arbiters in the tree.

Test Plan:
- Reset, then i_req=4'b1111, all reads, no lock -> o_gnt sequence 0001,0010,0100,1000,0001; each o_rvalid matches the previous cycle's o_gnt; o_rdata equals the preloaded memory word.
- Requester 2 writes adr=9'h1A5, wen=2'b01, wdata=16'hBEEF, then reads the same address -> o_mem_wen=2'b01 on the write; o_rdata low byte=8'hEF, high byte unchanged.
- Requester 1 has i_lock=1 and continuous i_req, others request, MAX_BURST=8 -> exactly 8 consecutive grants to 1, then grant to 2, with ptr_q=2.
- Requester 3 locks and drops i_req after 3 grants -> FSM returns to IDLE; the next grant follows ptr_q=0.
- Read granted, then rst_n asserted mid-cycle -> o_rvalid=0, o_gnt=0, ptr_q=0 asynchronously; after release a single i_req[1] is granted the same cycle.
- With XIL_MEM_ARB_STATS_EN: requester 0 is held off by a locked requester 1 for 5 cycles -> o_wait_cnt[15:0]=5; force 70000 wait cycles -> value 16'hFFFF.
